// File: rtl/ram_bist_if.sv
// RAM pin bundle between the BIST master and a 2^AW x DW synchronous RAM.
interface ram_bist_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_datain;
    logic          ram_read;
    logic          ram_write;
    logic [DW-1:0] ram_dataout;

    modport master (
        output ram_addr, ram_datain, ram_read, ram_write,
        input  ram_dataout
    );

    modport slave (
        input  ram_addr, ram_datain, ram_read, ram_write,
        output ram_dataout
    );
endinterface

// File: rtl/ram_bist_master.sv
// March-style BIST controller: write P, read/check P, write ~P, read/check ~P,
// then report pass, mismatch count and first failing address.
module ram_bist_master #(
    parameter int            AW   = 4,
    parameter int            DW   = 4,
    parameter logic [DW-1:0] SEED = 4'b1010
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    ram_bist_if.master    bus,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW+1:0] err_count,
    output logic [AW-1:0] first_fail_addr,
    output logic          fail_seen
);

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DRAIN, DONE} state_t;

    state_t        state, state_n;
    logic [AW-1:0] addr_n;
    logic [AW-1:0] addr_inc;
    logic [DW-1:0] datain_n;
    logic          read_n;
    logic          write_n;
    logic          accept;
    logic          last;

    logic          vld_p1;
    logic [DW-1:0] exp_p1;
    logic [AW-1:0] addr_p1;

    // Background pattern: address zero-extended/truncated to DW bits, XOR seed.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [AW+DW-1:0] ext;
        ext = {{DW{1'b0}}, a};
        return ext[DW-1:0] ^ SEED;
    endfunction

    assign last     = &bus.ram_addr;
    assign addr_inc = bus.ram_addr + 1'b1;

    always_comb begin
        state_n  = state;
        addr_n   = bus.ram_addr;
        datain_n = '0;
        read_n   = 1'b0;
        write_n  = 1'b0;
        accept   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_n  = W0;
                    addr_n   = '0;
                    write_n  = 1'b1;
                    datain_n = pat({AW{1'b0}});
                end
            end
            W0: begin
                if (last) begin
                    state_n = R0;
                    addr_n  = '0;
                    read_n  = 1'b1;
                end else begin
                    addr_n   = addr_inc;
                    write_n  = 1'b1;
                    datain_n = pat(addr_inc);
                end
            end
            R0: begin
                if (last) begin
                    state_n  = W1;
                    addr_n   = '0;
                    write_n  = 1'b1;
                    datain_n = ~pat({AW{1'b0}});
                end else begin
                    addr_n = addr_inc;
                    read_n = 1'b1;
                end
            end
            W1: begin
                if (last) begin
                    state_n = R1;
                    addr_n  = '0;
                    read_n  = 1'b1;
                end else begin
                    addr_n   = addr_inc;
                    write_n  = 1'b1;
                    datain_n = ~pat(addr_inc);
                end
            end
            R1: begin
                if (last) begin
                    state_n = DRAIN;
                    addr_n  = '0;
                end else begin
                    addr_n = addr_inc;
                    read_n = 1'b1;
                end
            end
            DRAIN: begin
                state_n = DONE;
                addr_n  = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Stage p0 -> p1: RAM pins registered; a read seen on the pins arms a check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.ram_addr    <= '0;
            bus.ram_datain  <= '0;
            bus.ram_read    <= 1'b0;
            bus.ram_write   <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            fail_seen       <= 1'b0;
            vld_p1          <= 1'b0;
        end else begin
            state          <= state_n;
            bus.ram_addr   <= addr_n;
            bus.ram_datain <= datain_n;
            bus.ram_read   <= read_n;
            bus.ram_write  <= write_n;
            busy           <= (state_n inside {W0, R0, W1, R1, DRAIN});
            vld_p1         <= bus.ram_read;
            if (accept) begin
                done            <= 1'b0;
                pass            <= 1'b0;
                err_count       <= '0;
                first_fail_addr <= '0;
                fail_seen       <= 1'b0;
            end else begin
                // The last R1 compare lands while entering DONE, so the verdict is taken one edge later.
                if (state == DONE) begin
                    done <= 1'b1;
                    pass <= (err_count == '0);
                end
                if (vld_p1 && (bus.ram_dataout != exp_p1)) begin
                    err_count <= err_count + 1'b1;
                    if (!fail_seen) begin
                        first_fail_addr <= addr_p1;
                        fail_seen       <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        exp_p1  <= (state == R1) ? ~pat(bus.ram_addr) : pat(bus.ram_addr);
        addr_p1 <= bus.ram_addr;
    end

endmodule

// File: doc/ram_bist_master.md
Name: ram_bist_master

Overview:
- Initiator-side built-in self-test controller for the 16x4 synchronous RAM.
- Drives the RAM's addr/datain/read/write pins through a fixed four-phase march sequence: write pattern, read and check, write inverse, read and check.
- Compares the registered read data (1-cycle read latency; dataout=0 when read is low) against expected values.
- Reports done, pass, error count and first failing address to a top-level test harness.

Parameters:
- AW, 4, address width; depth = 2^AW words.
- DW, 4, data width.
- SEED, 4'b1010, DW-bit pattern seed; P(a) = zero-extended a[DW-1:0] XOR SEED.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse or level; sampled only in IDLE or DONE.
- ram_addr  output  AW  to RAM addr.
- ram_datain  output  DW  to RAM datain.
- ram_read  output  1  to RAM read.
- ram_write  output  1  to RAM write.
- ram_dataout  input  DW  from RAM dataout (registered, 1-cycle latency).
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  high in DONE, held until next start or rst.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  AW+2  total mismatches (max 2*2^AW, cannot overflow).
- first_fail_addr  output  AW  address of first mismatch; 0 if none.
- fail_seen  output  1  set on first mismatch.

Behaviour:
- All outputs are registered. Reset, and every output's reset value, is 0; FSM goes to IDLE.
- States: IDLE -> W0 -> R0 -> W1 -> R1 -> DRAIN -> DONE.
- Addresses are ascending 0..2^AW-1 within each of W0/R0/W1/R1. The address counter wraps to 0 on each phase change.
- Accepting start: start=1 sampled in IDLE or DONE clears err_count, first_fail_addr, fail_seen, done and pass, and registers W0 outputs (write=1, addr=0, datain=P(0)).
- W0: ram_write=1, ram_read=0, datain=P(addr); 2^AW cycles.
- R0: ram_read=1, ram_write=0; 2^AW cycles.
- W1: ram_write=1, datain=~P(addr); 2^AW cycles.
- R1: ram_read=1; 2^AW cycles.
- DRAIN: all RAM controls 0; 1 cycle. DONE is entered at the following edge.
- Read/write exclusivity: ram_read and ram_write are never both 1. In W0/W1, ram_read=0. In R0/R1, ram_write=0 and ram_datain=0.
- Compare pipeline:
  - Each read-issue cycle loads chk_valid_q=1, exp_q=expected value and addr_q=addr.
  - On the next cycle, ram_dataout is compared with exp_q at the following edge.
  - On mismatch: err_count += 1; if fail_seen=0, first_fail_addr <= addr_q and fail_seen <= 1.
  - The pipeline runs independently of the FSM. The last R0 compare overlaps the first W1 cycle; the last R1 compare occurs in DRAIN.
- Timing with AW=4 (edge E0 samples start):
  - Writes at E1..E16; reads issued cycles 17..32 and 49..64; inverse writes at E33..E48.
  - Final compare at E65; done=1 and pass valid from E66, i.e. done rises 66 edges after start is sampled.
  - General formula: 4*2^AW+2 edges.
- busy=1 in W0..DRAIN.
- start while busy is ignored.
- start in DONE restarts the test, clearing results.
- rst mid-operation: at that edge all RAM controls drop to 0, the FSM returns to IDLE, and results clear. RAM contents are left as is.
- The pattern and its inverse toggle every data bit at every address across the two passes.

Test Plan:
- Fault-free RAM model, AW=4, SEED=1010, start pulse -> W0 writes 1010,1011,...,0101 at addr 0..15; done rises exactly 66 edges after start; pass=1, err_count=0, fail_seen=0, first_fail_addr=0.
- RAM model with addr 5 bit0 stuck-at-1 -> P(5)=1111 reads OK; ~P(5)=0000 reads 0001 -> err_count=1, first_fail_addr=5, fail_seen=1, pass=0.
- Stuck-at-0 on bit3 at addr 2 and addr 9 -> err_count=2 (2: pass0 P=1000; 9: pass1 ~P=1100), first_fail_addr=2.
- start pulsed again at cycle 30 while busy -> ignored; done still at edge 66. Then start held high in DONE -> second run begins with results cleared at that edge.
- rst asserted at cycle 20 (during R0) -> next cycle ram_read=ram_write=0, busy=0, err_count=0, IDLE. A subsequent start completes normally with pass=1.
- Protocol monitor over the whole run -> ram_read&ram_write never 1; ram_read=0 during W0/W1 and DRAIN; ram_write=0 during R0/R1 and DRAIN; each phase presents addr 0..15 exactly once in order.
